// File: rtl/instr_encoder.sv
// Instruction encoder / program-memory writer: packs symbolic commands into 8-bit
// instruction bytes at an auto-incrementing address. Optional ENC_CHECKSUM_EN adds a running XOR checksum.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [2:0]        cmd_a,
  input  logic [2:0]        cmd_b,
  input  logic [7:0]        cmd_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              err
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  // state    | meaning
  // IDLE     | waiting for a command; cmd_ready when not full and not clearing
  // EMIT_OP  | opcode byte on the memory port
  // EMIT_IMM | immediate byte on the memory port (LDI/JMP/CALL)
  typedef enum logic [1:0] {IDLE, EMIT_OP, EMIT_IMM} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST  = {1'b0, {ADDR_W{1'b1}}};

  state_t          state;
  logic            ready_en;
  logic [7:0]      imm_q;
  logic            two_q;
  logic [7:0]      byte0;
  logic            legal;
  logic            two_byte;
  logic            reject;
  logic [ADDR_W:0] count_nxt;

  always_comb begin
    byte0    = 8'h00;
    legal    = 1'b1;
    two_byte = 1'b0;
    case (cmd_op)
      4'd0:  byte0 = 8'hC0;
      4'd1:  byte0 = {2'b00, cmd_a, cmd_b};
      4'd2:  begin byte0 = {5'b01000, cmd_a}; two_byte = 1'b1; end
      4'd3:  byte0 = {5'b01001, cmd_a};
      4'd4:  byte0 = {5'b01010, cmd_a};
      4'd5:  byte0 = {5'b10000, cmd_a};
      4'd6:  byte0 = 8'h88;
      4'd7:  byte0 = {5'b01011, cmd_a};
      4'd8:  byte0 = {5'b01100, cmd_a};
      4'd9:  begin byte0 = 8'hC3; two_byte = 1'b1; end
      4'd10: begin byte0 = 8'hC1; two_byte = 1'b1; end
      4'd11: byte0 = 8'hC2;
      4'd12: byte0 = 8'hFF;
      default: legal = 1'b0;
    endcase
  end

  // A two-byte op with one slot left is refused whole rather than split.
  assign reject    = ~legal | (two_byte & (count == LAST));
  assign count_nxt = count + 1'b1;
  assign cmd_ready = ready_en & (state == IDLE) & ~full & ~clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready_en  <= 1'b0;
      imm_q     <= 8'h00;
      two_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      count     <= '0;
      busy      <= 1'b0;
      full      <= 1'b0;
      err       <= 1'b0;
`ifdef ENC_CHECKSUM_EN
      checksum  <= 8'h00;
`endif
    end else begin
      ready_en <= 1'b1;
      if (clear) begin
        state  <= IDLE;
        mem_we <= 1'b0;
        count  <= '0;
        busy   <= 1'b0;
        full   <= 1'b0;
        err    <= 1'b0;
`ifdef ENC_CHECKSUM_EN
        checksum <= 8'h00;
`endif
      end else begin
        case (state)
          IDLE: begin
            mem_we <= 1'b0;
            if (cmd_valid && cmd_ready) begin
              if (reject) begin
                err <= 1'b1;
              end else begin
                state     <= EMIT_OP;
                mem_we    <= 1'b1;
                mem_addr  <= count[ADDR_W-1:0];
                mem_wdata <= byte0;
                count     <= count_nxt;
                full      <= (count_nxt == DEPTH);
                busy      <= 1'b1;
                imm_q     <= cmd_imm;
                two_q     <= two_byte;
`ifdef ENC_CHECKSUM_EN
                checksum  <= checksum ^ byte0;
`endif
              end
            end
          end
          EMIT_OP: begin
            if (two_q) begin
              state     <= EMIT_IMM;
              mem_we    <= 1'b1;
              mem_addr  <= count[ADDR_W-1:0];
              mem_wdata <= imm_q;
              count     <= count_nxt;
              full      <= (count_nxt == DEPTH);
`ifdef ENC_CHECKSUM_EN
              checksum  <= checksum ^ imm_q;
`endif
            end else begin
              state  <= IDLE;
              mem_we <= 1'b0;
              busy   <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            mem_we <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: randomized commands against a byte-level
// reference model, plus directed clear / reset-abort / fill-to-full scenarios.
module tb_instr_encoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'd0;
  logic [2:0] cmd_a = 3'd0;
  logic [2:0] cmd_b = 3'd0;
  logic [7:0] cmd_imm = 8'd0;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [8:0] count;
  logic       busy;
  logic       full;
  logic       err;
`ifdef ENC_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int       m_cnt = 0;
  bit       m_err = 1'b0;
  bit [7:0] m_chk = 8'h00;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_imm(cmd_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .busy(busy), .full(full), .err(err)
`ifdef ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_two(input int op);
    return (op == 2) || (op == 9) || (op == 10);
  endfunction

  function automatic int enc_byte(input int op, input int a, input int b);
    case (op)
      0:  return 192;
      1:  return a * 8 + b;
      2:  return 64 + a;
      3:  return 64 + 8 + a;
      4:  return 64 + 16 + a;
      5:  return 128 + a;
      6:  return 128 + 8;
      7:  return 64 + 24 + a;
      8:  return 64 + 32 + a;
      9:  return 195;
      10: return 193;
      11: return 194;
      12: return 255;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_err = 1'b0;
    m_chk = 8'h00;
  endtask

  // Present a command, wait (bounded) for cmd_ready, return just after the transfer edge.
  task automatic send(input int op, input int a, input int b, input int imm);
    int t;
    @(negedge clk);
    cmd_op = 4'(op); cmd_a = 3'(a); cmd_b = 3'(b); cmd_imm = 8'(imm);
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op  = 4'($urandom);
    cmd_a   = 3'($urandom);
    cmd_b   = 3'($urandom);
    cmd_imm = 8'($urandom);
  endtask

  // Cycle-accurate check of one command against the model.
  task automatic do_cmd(input int op, input int a, input int b, input int imm);
    int       nb;
    int       base;
    bit [7:0] eb[2];
    nb   = 0;
    base = m_cnt;
    if (enc_byte(op, a, b) < 0 || (is_two(op) && m_cnt == 255)) begin
      m_err = 1'b1;
    end else begin
      eb[0] = 8'(enc_byte(op, a, b));
      eb[1] = 8'(imm);
      nb = is_two(op) ? 2 : 1;
    end
    send(op, a, b, imm);
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      check("we", 32'(mem_we), 32'd1);
      check("addr", 32'(mem_addr), 32'(base + k));
      check("data", 32'(mem_wdata), 32'(eb[k]));
      check("busy", 32'(busy), 32'd1);
      check("count_wr", 32'(count), 32'(base + k + 1));
      m_chk = m_chk ^ eb[k];
    end
    m_cnt = base + nb;
    @(negedge clk);
    check("we_idle", 32'(mem_we), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("count", 32'(count), 32'(m_cnt));
    check("err", 32'(err), 32'(m_err));
    check("full", 32'(full), 32'(m_cnt == 256));
    check("ready", 32'(cmd_ready), 32'(m_cnt != 256));
`ifdef ENC_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(m_chk));
`endif
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    #1;
    check("ready_in_clear", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    check("clear_count", 32'(count), 32'd0);
    check("clear_err", 32'(err), 32'd0);
    check("clear_full", 32'(full), 32'd0);
    model_reset();
  endtask

  initial begin
    int op;
    // reset values
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_wdata), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // MOV 3,5 -> 0x1D, then NOP 0xC0 (checksum 0xDD)
    do_cmd(1, 3, 5, 0);
    do_cmd(0, 0, 0, 0);
`ifdef ENC_CHECKSUM_EN
    check("checksum_dd", 32'(checksum), 32'hDD);
`endif

    // LDI 2, 0xA5 from an empty image
    do_clear();
    do_cmd(2, 2, 0, 8'hA5);

    // illegal op, then NOP
    do_cmd(14, 0, 0, 0);
    do_cmd(0, 0, 0, 0);

    // random mix
    for (int i = 0; i < 40; i++)
      do_cmd($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));

    // clear during EMIT_OP of CALL
    do_clear();
    do_cmd(1, 1, 2, 0);
    send(10, 0, 0, 8'h33);
    @(negedge clk);
    check("call_b0_we", 32'(mem_we), 32'd1);
    check("call_b0_data", 32'(mem_wdata), 32'hC1);
    clear = 1'b1;
    @(negedge clk);
    check("clr_we", 32'(mem_we), 32'd0);
    check("clr_count", 32'(count), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_ready", 32'(cmd_ready), 32'd0);
    clear = 1'b0;
    @(negedge clk);
    check("clr_we2", 32'(mem_we), 32'd0);
    check("clr_ready2", 32'(cmd_ready), 32'd1);
    model_reset();
    do_cmd(12, 0, 0, 0);

    // reset during EMIT_IMM of JMP
    send(9, 0, 0, 8'h5A);
    @(negedge clk);
    check("jmp_b0", 32'(mem_wdata), 32'hC3);
    @(negedge clk);
    check("jmp_b1", 32'(mem_wdata), 32'h5A);
    check("jmp_b1_we", 32'(mem_we), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_data", 32'(mem_wdata), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("arst_we_hold", 32'(mem_we), 32'd0);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);

    // fill to 255 with random commands, then JMP rejected, HLT fills
    while (m_cnt < 255) begin
      op = $urandom_range(0, 15);
      if (m_cnt == 254 && is_two(op)) op = 6;
      do_cmd(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
    end
    do_cmd(9, 0, 0, 8'h10);
    check("jmp_rej_err", 32'(err), 32'd1);
    check("jmp_rej_count", 32'(count), 32'd255);
    do_cmd(12, 0, 0, 0);
    check("full_addr", 32'(mem_addr), 32'hFF);
    check("full_flag", 32'(full), 32'd1);
    @(negedge clk);
    cmd_op = 4'd0;
    cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("full_no_we", 32'(mem_we), 32'd0);
    check("full_count", 32'(count), 32'd256);
    cmd_valid = 1'b0;
    do_clear();
    do_cmd(1, 3, 5, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
